uart_tx_scheduler: RTL

//   Shares one uart_tx instance among NUM_REQ byte producers with round-robin arbitration.

---
 rtl/uart_tx_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one uart_tx among NUM_REQ byte producers using round-robin arbitration.
//   One frame is in flight at a time. An optional idle gap follows each frame, and a
//   watchdog flags a transmitter that never reports done.
//
// Ports
//   i_Clock      system clock
//   i_Reset      synchronous, active-high reset
//   i_Req_DV     per-requester byte valid, held until acknowledged
//   i_Req_Byte   requester n byte at [8n+7:8n]
//   o_Req_Ack    one-cycle pulse for the requester whose byte was launched
//   o_Grant      one-hot owner of the current frame (LAUNCH/WAIT_DONE), else 0
//   o_Tx_DV      launch pulse to uart_tx i_Tx_DV
//   o_Tx_Byte    byte to uart_tx i_Tx_Byte, held until the next launch
//   i_Tx_Active  uart_tx o_Tx_Active
//   i_Tx_Done    uart_tx o_Tx_Done
//   o_Busy       high in every state except IDLE
//   o_Timeout    sticky watchdog flag, cleared only by reset
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 0,
    parameter int TIMEOUT_CLKS = 1000
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic [NUM_REQ-1:0]     i_Req_DV,
    input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
    output logic [NUM_REQ-1:0]     o_Req_Ack,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_Tx_DV,
    output logic [7:0]             o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done,
    output logic                   o_Busy,
    output logic                   o_Timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int GAP_W = ($clog2(GAP_CLKS + 1) > 0) ? $clog2(GAP_CLKS + 1) : 1;

    // The watchdog fires when its incremented value would reach TIMEOUT_CLKS-1, so
    // the flag is visible exactly TIMEOUT_CLKS cycles after the launch cycle.
    localparam logic [WD_W-1:0]  WD_FIRE  = WD_W'(TIMEOUT_CLKS - 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [7:0]         byte_q, byte_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               timeout_q, timeout_d;

    logic [2*NUM_REQ-1:0] rot_all;
    logic [IDX_W-1:0]     arb_off;
    logic [IDX_W:0]       arb_sum;
    logic [IDX_W-1:0]     arb_idx;
    logic [7:0]           arb_byte;
    logic [NUM_REQ-1:0]   sel_onehot;

    // Rotate the request vector so bit 0 is the requester at the pointer; the first
    // set bit of the rotated vector is then the round-robin winner's offset.
    assign rot_all = {i_Req_DV, i_Req_DV} >> ptr_q;

    always_comb begin
        arb_off  = '0;
        arb_sum  = '0;
        arb_idx  = '0;
        arb_byte = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot_all[j]) begin
                arb_off = IDX_W'(j);
            end
        end
        arb_sum = {1'b0, ptr_q} + {1'b0, arb_off};
        if (arb_sum >= (IDX_W + 1)'(NUM_REQ)) begin
            arb_sum = arb_sum - (IDX_W + 1)'(NUM_REQ);
        end
        arb_idx = arb_sum[IDX_W-1:0];
        for (int j = 0; j < NUM_REQ; j++) begin
            if (arb_idx == IDX_W'(j)) begin
                arb_byte = i_Req_Byte[8*j +: 8];
            end
        end
    end

    assign sel_onehot = NUM_REQ'(1) << sel_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            byte_q    <= '0;
            wd_q      <= '0;
            gap_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            byte_q    <= byte_d;
            wd_q      <= wd_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        byte_d    = byte_q;
        wd_d      = wd_q;
        gap_d     = gap_q;
        timeout_d = timeout_q;
        o_Req_Ack = '0;
        o_Grant   = '0;
        o_Tx_DV   = 1'b0;
        o_Busy    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Never launch over a frame still on the wire, e.g. after this block
                // alone was reset mid-frame.
                if (|i_Req_DV && !i_Tx_Active) begin
                    sel_d   = arb_idx;
                    byte_d  = arb_byte;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                o_Tx_DV   = 1'b1;
                o_Req_Ack = sel_onehot;
                o_Grant   = sel_onehot;
                o_Busy    = 1'b1;
                ptr_d     = (sel_q == IDX_LAST) ? '0 : sel_q + 1'b1;
                wd_d      = '0;
                state_d   = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                o_Grant = sel_onehot;
                o_Busy  = 1'b1;
                wd_d    = wd_q + 1'b1;
                // Done wins over a simultaneous watchdog expiry.
                if (i_Tx_Done || (wd_q == WD_FIRE)) begin
                    if (!i_Tx_Done) begin
                        timeout_d = 1'b1;
                    end
                    gap_d   = '0;
                    state_d = (GAP_CLKS == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                o_Busy = 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_Tx_Byte = byte_q;
    assign o_Timeout = timeout_q;

endmodule
